// File: rtl/dff.sv
// Width-parameterised D flip-flop with asynchronous active-low clear/preset and q/qb outputs.
// Optional clock enable input ce is added when DFF_CE_EN is defined.
module dff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] CLR_VAL = '0,
  parameter logic [WIDTH-1:0] PRE_VAL = '1
) (
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  input  logic             clk,
  input  logic             pre,
  input  logic             clr
`ifdef DFF_CE_EN
  ,
  input  logic             ce
`endif
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] force_hi;
  logic [WIDTH-1:0] force_lo;

  always_comb begin
    q_d = d;
`ifdef DFF_CE_EN
    if (!ce) begin
      q_d = q_q;
    end
`endif
  end

  // Resolve clr/pre priority into a per-bit set/reset pair, so releasing clr
  // while pre is still low produces an edge that loads PRE_VAL at once.
  always_comb begin
    force_hi = '0;
    force_lo = '0;
    if (!clr) begin
      force_hi = CLR_VAL;
      force_lo = ~CLR_VAL;
    end else if (!pre) begin
      force_hi = PRE_VAL;
      force_lo = ~PRE_VAL;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic bit_q;

    always_ff @(posedge clk or posedge force_lo[i] or posedge force_hi[i]) begin
      if (force_lo[i]) begin
        bit_q <= 1'b0;
      end else if (force_hi[i]) begin
        bit_q <= 1'b1;
      end else begin
        bit_q <= q_d[i];
      end
    end

    assign q_q[i] = bit_q;
  end

  assign q  = q_q;
  assign qb = ~q_q;

endmodule

// File: tb/tb_dff.sv
// Self-checking bench for dff: a 1-bit default instance and a 4-bit instance
// (CLR_VAL=5, PRE_VAL=A) checked against a behavioural model.
module tb_dff;

  logic       clk = 1'b0;
  logic       clr;
  logic       pre;
  logic       dOne;
  logic       qOne;
  logic       qbOne;
  logic [3:0] dWide;
  logic [3:0] qWide;
  logic [3:0] qbWide;

  int total = 0;
  int bad   = 0;

  logic       expOne;
  logic [3:0] expWide;
  bit         modelValid = 1'b0;

  dff u_one (
    .d   (dOne),
    .q   (qOne),
    .qb  (qbOne),
    .clk (clk),
    .pre (pre),
    .clr (clr)
  );

  dff #(
    .WIDTH   (4),
    .CLR_VAL (4'h5),
    .PRE_VAL (4'hA)
  ) u_wide (
    .d   (dWide),
    .q   (qWide),
    .qb  (qbWide),
    .clk (clk),
    .pre (pre),
    .clr (clr)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h at t=%0t", name, got, want, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_q1"},  {3'b000, qOne},  {3'b000, expOne});
    checkOutput({tag, "_qb1"}, {3'b000, qbOne}, {3'b000, ~expOne});
    checkOutput({tag, "_qw"},  qWide,  expWide);
    checkOutput({tag, "_qbw"}, qbWide, ~expWide);
  endtask

  // Drive inputs between clock edges; clr/pre take effect without a clock,
  // and a released or unchanged control leaves the stored value alone.
  task automatic applyStimulus(input logic c, input logic p, input logic d1, input logic [3:0] dw);
    clr   = c;
    pre   = p;
    dOne  = d1;
    dWide = dw;
    if (!c) begin
      expOne     = 1'b0;
      expWide    = 4'h5;
      modelValid = 1'b1;
    end else if (!p) begin
      expOne     = 1'b1;
      expWide    = 4'hA;
      modelValid = 1'b1;
    end
    #1;
    if (modelValid) checkAll("async");
  endtask

  // Compare process: every rising edge with both controls high loads d.
  initial begin
    forever begin
      @(posedge clk);
      if (clr === 1'b1 && pre === 1'b1) begin
        expOne     = dOne;
        expWide    = dWide;
        modelValid = 1'b1;
      end
      #1;
      if (modelValid) checkAll("edge");
    end
  end

  initial begin
    clr   = 1'b1;
    pre   = 1'b1;
    dOne  = 1'b0;
    dWide = 4'h0;

    @(posedge clk);
    #2;
    checkOutput("first_q",  {3'b000, qOne},  4'h0);
    checkOutput("first_qb", {3'b000, qbOne}, 4'h1);

    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'h3);
    @(posedge clk);
    #2;
    checkOutput("load_q1",  {3'b000, qOne}, 4'h1);
    checkOutput("load_qw",  qWide,  4'h3);
    checkOutput("load_qbw", qbWide, 4'hC);

    @(negedge clk);
    #2;
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h9);
    checkOutput("dchg_hold_q1", {3'b000, qOne}, 4'h1);
    checkOutput("dchg_hold_qw", qWide, 4'h3);

    @(negedge clk);
    #2;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
    checkOutput("pre_q1", {3'b000, qOne}, 4'h1);
    checkOutput("pre_qw", qWide, 4'hA);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("pre_hold_qw", qWide, 4'hA);

    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h6);
    checkOutput("pre_rel_qw", qWide, 4'hA);
    @(posedge clk);
    #2;
    checkOutput("pre_rel_load_qw", qWide, 4'h6);
    checkOutput("pre_rel_load_q1", {3'b000, qOne}, 4'h0);

    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'hF);
    checkOutput("both_q1",  {3'b000, qOne},  4'h0);
    checkOutput("both_qb1", {3'b000, qbOne}, 4'h1);
    checkOutput("both_qw",  qWide, 4'h5);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'hF);
    checkOutput("clr_rel_q1", {3'b000, qOne}, 4'h1);
    checkOutput("clr_rel_qw", qWide, 4'hA);
    @(posedge clk);
    #2;
    checkOutput("clr_rel_hold_qw", qWide, 4'hA);

    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'hF);
    @(posedge clk);
    #2;
    checkOutput("final_load_qw", qWide, 4'hF);

    // Randomised phase: mostly free-running loads with occasional clr/pre
    // pulses, sometimes changing twice within one low clock phase.
    repeat (300) begin
      @(negedge clk);
      begin
        int r;
        r = $urandom_range(0, 15);
        applyStimulus(r != 0, (r != 1) && (r != 2), 1'($urandom), 4'($urandom));
        if ($urandom_range(0, 3) == 0) begin
          r = $urandom_range(0, 7);
          applyStimulus(r != 0, r != 1, 1'($urandom), 4'($urandom));
        end
      end
    end

    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h0);
    @(posedge clk);
    #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
